alu_muldiv: RTL and testbench

Iterative unsigned multiply/divide unit for the 8-bit core's ALU. It sits directly upstream of the ALU result multiplexer: its `lo` and `hi` outputs drive two of the mux's data inputs, the product or quotient and the high product or remainder. The unit accepts a start request and completes one shift-add or restoring-subtract step per clock. It presents registered results with a single-cycle `done` strobe. The control unit stalls on `busy` and selects the mux input once `done` is seen.

---
 rtl/alu_muldiv.sv | 159 +++++++++++++++
 tb/tb_alu_muldiv.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// Iterative unsigned multiply / restoring divide, one step per clock.
// Ports: clk, rst_n, start/op/a/b request, busy/done status, lo/hi/dbz results.
module alu_muldiv #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] lo,
  output logic [N-1:0] hi,
  output logic         dbz
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic          w_load;
  logic          w_step;
  logic          w_last;

  logic          r_op;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic [CW-1:0] r_cnt;
  logic [2*N-1:0] r_acc;
  logic [N-1:0]  r_rem;
  logic [N-1:0]  r_quo;

  logic [N-1:0]  r_lo;
  logic [N-1:0]  r_hi;
  logic          r_dbz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    w_last = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (r_cnt == CW'(N - 1)) begin
          w_last = 1'b1;
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Multiply: high half accumulates, multiplier sits in the low half
  // and shifts out LSB first as product bits shift in from the top.
  logic [N:0]     w_sum;
  logic [2*N-1:0] w_acc_nx;

  assign w_sum    = {1'b0, r_acc[2*N-1:N]}
                  + {1'b0, (r_acc[0] ? r_a : {N{1'b0}})};
  assign w_acc_nx = {w_sum, r_acc[N-1:1]};

  // Divide: dividend shifts out of r_quo MSB first while quotient
  // bits shift in at the bottom.  With b == 0 every trial succeeds,
  // which yields all-ones quotient and remainder == a naturally.
  logic [N:0]   w_shift;
  logic [N+1:0] w_diff;
  logic         w_qbit;
  logic [N-1:0] w_rem_nx;
  logic [N-1:0] w_quo_nx;
  logic         w_unused;

  assign w_shift  = {r_rem, r_quo[N-1]};
  assign w_diff   = {1'b0, w_shift} - {2'b00, r_b};
  assign w_qbit   = ~w_diff[N+1];
  assign w_rem_nx = w_qbit ? w_diff[N-1:0] : w_shift[N-1:0];
  assign w_quo_nx = {r_quo[N-2:0], w_qbit};
  // Kept remainder is always below b, so this bit is never set.
  assign w_unused = w_diff[N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op  <= 1'b0;
      r_a   <= '0;
      r_b   <= '0;
      r_cnt <= '0;
      r_acc <= '0;
      r_rem <= '0;
      r_quo <= '0;
      r_lo  <= '0;
      r_hi  <= '0;
      r_dbz <= 1'b0;
    end else begin
      if (w_load) begin
        r_op  <= op;
        r_a   <= a;
        r_b   <= b;
        r_cnt <= '0;
        r_acc <= {{N{1'b0}}, b};
        r_rem <= '0;
        r_quo <= a;
      end else if (w_step) begin
        r_cnt <= r_cnt + CW'(1);
        if (r_op) begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
        end else begin
          r_acc <= w_acc_nx;
        end
      end
      if (w_last) begin
        if (r_op) begin
          r_lo  <= w_quo_nx;
          r_hi  <= w_rem_nx;
          r_dbz <= (r_b == '0);
        end else begin
          r_lo  <= w_acc_nx[N-1:0];
          r_hi  <= w_acc_nx[2*N-1:N];
          r_dbz <= 1'b0;
        end
      end
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign lo   = r_lo;
  assign hi   = r_hi;
  assign dbz  = r_dbz;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed and random ops
// against an arithmetic reference model, plus timing and reset.
module tb_alu_muldiv;

  localparam int N = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         op    = 1'b0;
  logic [N-1:0] a     = '0;
  logic [N-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] lo;
  logic [N-1:0] hi;
  logic         dbz;

  int n_cmp = 0;
  int n_bad = 0;

  logic [N-1:0] p_lo  = '0;
  logic [N-1:0] p_hi  = '0;
  logic         p_dbz = 1'b0;

  alu_muldiv #(.N(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .lo   (lo),
    .hi   (hi),
    .dbz  (dbz)
  );

  always #5 clk = ~clk;

  function automatic void model(
    input  logic         o,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic [N-1:0] ml,
    output logic [N-1:0] mh,
    output logic         md
  );
    logic [2*N-1:0] prod;
    prod = {{N{1'b0}}, x} * {{N{1'b0}}, y};
    if (!o) begin
      ml = prod[N-1:0];
      mh = prod[2*N-1:N];
      md = 1'b0;
    end else if (y == '0) begin
      ml = '1;
      mh = x;
      md = 1'b1;
    end else begin
      ml = x / y;
      mh = x % y;
      md = 1'b0;
    end
  endfunction

  task automatic do_op(
    input logic         o,
    input logic [N-1:0] x,
    input logic [N-1:0] y,
    input bit           disturb
  );
    logic [N-1:0] el;
    logic [N-1:0] eh;
    logic         ed;
    model(o, x, y, el, eh, ed);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1 || done !== 1'b0 || lo !== p_lo ||
          hi !== p_hi || dbz !== p_dbz) begin
        n_bad++;
        $display("FAIL run_cyc%0d op=%0d a=%h b=%h: busy=%b done=%b lo=%h hi=%h dbz=%b want busy=1 done=0 lo=%h hi=%h dbz=%b",
                 i, o, x, y, busy, done, lo, hi, dbz, p_lo, p_hi, p_dbz);
      end
      if (disturb) begin
        start = 1'($urandom);
        op    = 1'($urandom);
        a     = N'($urandom);
        b     = N'($urandom);
      end
    end
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b1 || lo !== el ||
        hi !== eh || dbz !== ed) begin
      n_bad++;
      $display("FAIL result op=%0d a=%h b=%h: busy=%b done=%b lo=%h hi=%h dbz=%b want busy=0 done=1 lo=%h hi=%h dbz=%b",
               o, x, y, busy, done, lo, hi, dbz, el, eh, ed);
    end
    p_lo  = el;
    p_hi  = eh;
    p_dbz = ed;
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || lo !== '0 ||
        hi !== '0 || dbz !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_values: busy=%b done=%b lo=%h hi=%h dbz=%b want all 0",
               busy, done, lo, hi, dbz);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_mul();
    do_op(1'b0, 8'd200, 8'd150, 1'b0);
    do_op(1'b0, 8'hFF, 8'hFF, 1'b0);
    do_op(1'b0, 8'h00, 8'hFF, 1'b0);
  endtask

  task automatic test_div();
    do_op(1'b1, 8'd200, 8'd7, 1'b0);
    do_op(1'b1, 8'd5, 8'd9, 1'b0);
  endtask

  task automatic test_dbz();
    do_op(1'b1, 8'h5A, 8'h00, 1'b0);
    do_op(1'b0, 8'h11, 8'h03, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] el;
    logic [N-1:0] eh;
    logic         ed;
    bit           exp_done;
    model(1'b0, 8'd3, 8'd4, el, eh, ed);
    @(negedge clk);
    start = 1'b1;
    op    = 1'b0;
    a     = 8'd3;
    b     = 8'd4;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      @(negedge clk);
      exp_done = ((c % (N + 1)) == N);
      if (exp_done) begin
        p_lo  = el;
        p_hi  = eh;
        p_dbz = ed;
      end
      n_cmp++;
      if (done !== exp_done || busy !== !exp_done || lo !== p_lo ||
          hi !== p_hi || dbz !== p_dbz) begin
        n_bad++;
        $display("FAIL held_start edge%0d: done=%b busy=%b lo=%h hi=%h dbz=%b want done=%b busy=%b lo=%h hi=%h dbz=%b",
                 c, done, busy, lo, hi, dbz, exp_done, !exp_done, p_lo, p_hi, p_dbz);
      end
    end
    start = 1'b0;
    repeat (N + 2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || lo !== el || hi !== eh) begin
      n_bad++;
      $display("FAIL held_drain: busy=%b lo=%h hi=%h want busy=0 lo=%h hi=%h",
               busy, lo, hi, el, eh);
    end
  endtask

  task automatic test_start_during_run();
    do_op(1'b1, 8'd200, 8'd7, 1'b1);
    do_op(1'b0, 8'd200, 8'd150, 1'b1);
  endtask

  task automatic test_reset_during_run();
    do_op(1'b0, 8'd200, 8'd150, 1'b0);
    @(negedge clk);
    start = 1'b1;
    op    = 1'b1;
    a     = 8'd200;
    b     = 8'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || lo !== '0 ||
        hi !== '0 || dbz !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset_run: busy=%b done=%b lo=%h hi=%h dbz=%b want all 0",
               busy, done, lo, hi, dbz);
    end
    @(negedge clk);
    rst_n = 1'b1;
    p_lo  = '0;
    p_hi  = '0;
    p_dbz = 1'b0;
    for (int i = 0; i < N + 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0 || lo !== '0 || hi !== '0) begin
        n_bad++;
        $display("FAIL post_reset_quiet%0d: done=%b busy=%b lo=%h hi=%h want 0 0 0 0",
                 i, done, busy, lo, hi);
      end
    end
    do_op(1'b1, 8'd200, 8'd7, 1'b0);
  endtask

  task automatic test_random();
    logic         o;
    logic [N-1:0] x;
    logic [N-1:0] y;
    for (int k = 0; k < 24; k++) begin
      o = 1'($urandom_range(0, 1));
      x = N'($urandom);
      y = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom);
      do_op(o, x, y, bit'(k % 2));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_dbz();
    test_back_to_back();
    test_start_during_run();
    test_reset_during_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
